// File: rtl/nlm_pkg.sv
// Shared widths, defaults and FSM encoding for the NLM weight normalizer.
package nlm_pkg;

  localparam int unsigned PIX_WIDTH_DEF = 12;
  localparam int unsigned W_WIDTH_DEF   = 8;
  localparam int unsigned LENGTH_DEF    = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } nlm_state_e;

  function automatic int unsigned num_width(input int unsigned pix_w,
                                            input int unsigned w_w,
                                            input int unsigned len);
    return pix_w + w_w + $clog2(len);
  endfunction

  function automatic int unsigned den_width(input int unsigned w_w,
                                            input int unsigned len);
    return w_w + $clog2(len);
  endfunction

endpackage

// File: rtl/nlm_seq_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
module nlm_seq_divider
  import nlm_pkg::*;
#(
  parameter int unsigned Q_WIDTH = 12,
  parameter int unsigned D_WIDTH = 13,
  parameter int unsigned R_WIDTH = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [R_WIDTH-1:0] rem_init,
  input  logic [D_WIDTH-1:0] den,
  output logic               busy,
  output logic               done,
  output logic [Q_WIDTH-1:0] quot
);

  localparam int unsigned IW = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

  logic [R_WIDTH-1:0] rem;
  logic [D_WIDTH-1:0] den_r;
  logic [Q_WIDTH-1:0] q;
  logic [IW-1:0]      idx;
  logic [R_WIDTH-1:0] den_sh;
  logic               take;

  always_comb begin
    den_sh = R_WIDTH'(den_r) << idx;
    take   = busy && (rem >= den_sh);
  end

  // done is only meaningful on the last bit, so the live bit fills position 0
  assign done = busy && (idx == '0);

  always_comb begin
    quot    = q;
    quot[0] = take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      den_r <= '0;
      q     <= '0;
      idx   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem   <= rem_init;
      den_r <= den;
      q     <= '0;
      idx   <= IW'(Q_WIDTH - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (take) rem <= rem - den_sh;
      q[idx] <= take;
      if (idx == '0) busy <= 1'b0;
      else           idx  <= idx - IW'(1);
    end
  end

endmodule

// File: rtl/nlm_weight_normalizer.sv
// Normalizes an NLM weighted sum: round(num/den), with zero-den fallback and saturation.
//   state | meaning
//   IDLE  | waiting for num/den, in_ready high
//   DIV   | divider iterating, one quotient bit per cycle
//   DONE  | result presented, held until out_ready
module nlm_weight_normalizer
  import nlm_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = PIX_WIDTH_DEF,
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned LENGTH    = LENGTH_DEF,
  localparam int unsigned NUM_WIDTH = num_width(PIX_WIDTH, W_WIDTH, LENGTH),
  localparam int unsigned DEN_WIDTH = den_width(W_WIDTH, LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] in_num,
  input  logic [DEN_WIDTH-1:0] in_den,
  input  logic [PIX_WIDTH-1:0] in_center,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_WIDTH-1:0] out_pixel,
  output logic                 out_zero_den,
  output logic                 out_sat
);

  localparam int unsigned REM_WIDTH = NUM_WIDTH + 1;

  nlm_state_e state, state_nx;

  logic [REM_WIDTH-1:0] rem_init;
  logic [REM_WIDTH-1:0] den_lim;
  logic                 den_zero;
  logic                 too_big;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [PIX_WIDTH-1:0] div_quot;

  // Adding den/2 before truncating division gives round-half-up
  always_comb begin
    rem_init = REM_WIDTH'(in_num) + REM_WIDTH'(in_den >> 1);
    den_lim  = REM_WIDTH'(in_den) << PIX_WIDTH;
    den_zero = (in_den == '0);
    too_big  = (rem_init >= den_lim);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (den_zero || too_big) begin
            state_nx = DONE;
          end else begin
            div_start = 1'b1;
            state_nx  = DIV;
          end
        end
      end
      DIV:     if (div_done) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel    <= '0;
      out_zero_den <= 1'b0;
      out_sat      <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      if (den_zero) begin
        out_pixel    <= in_center;
        out_zero_den <= 1'b1;
        out_sat      <= 1'b0;
      end else if (too_big) begin
        out_pixel    <= '1;
        out_zero_den <= 1'b0;
        out_sat      <= 1'b1;
      end
    end else if (state == DIV && div_done) begin
      out_pixel    <= div_quot;
      out_zero_den <= 1'b0;
      out_sat      <= 1'b0;
    end
  end

  nlm_seq_divider #(
    .Q_WIDTH(PIX_WIDTH),
    .D_WIDTH(DEN_WIDTH),
    .R_WIDTH(REM_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .rem_init (rem_init),
    .den      (in_den),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot)
  );

endmodule

// File: tb/tb_nlm_weight_normalizer.sv
// Scoreboard bench for nlm_weight_normalizer: directed vectors, queued expectations, decoupled monitor.
module tb_nlm_weight_normalizer;

  localparam int PW = 12;
  localparam int NW = 25;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] in_num = '0;
  logic [DW-1:0] in_den = '0;
  logic [PW-1:0] in_center = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_pixel;
  logic          out_zero_den;
  logic          out_sat;

  always #5 clk = ~clk;

  nlm_weight_normalizer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num       (in_num),
    .in_den       (in_den),
    .in_center    (in_center),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pixel    (out_pixel),
    .out_zero_den (out_zero_den),
    .out_sat      (out_sat)
  );

  typedef struct {
    logic [PW-1:0] pix;
    logic          zd;
    logic          sat;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   fire_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Input-side monitor: an accepted input fires on the next rising edge
  always @(negedge clk)
    if (rst_n && in_valid && in_ready) fire_q.push_back(cyc + 1);

  exp_t          e;
  int            f;
  logic          prev_ov = 1'b0;
  logic [PW-1:0] held_pix;
  logic          held_zd, held_sat;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: pixel %0d with no job pending", out_pixel);
        end else begin
          e = exp_q.pop_front();
          f = (fire_q.size() != 0) ? fire_q.pop_front() : -1000;
          chk("pixel",    32'(out_pixel),    32'(e.pix));
          chk("zero_den", 32'(out_zero_den), 32'(e.zd));
          chk("sat",      32'(out_sat),      32'(e.sat));
          chk("latency",  32'(cyc - f + 1),  32'(e.lat));
        end
        held_pix = out_pixel;
        held_zd  = out_zero_den;
        held_sat = out_sat;
      end else if (out_valid) begin
        chk("hold_outputs", 32'({out_pixel, out_zero_den, out_sat}),
            32'({held_pix, held_zd, held_sat}));
      end
      if (out_valid) chk("in_ready_while_done", 32'(in_ready), 32'd0);
      prev_ov = out_valid;
    end
  end

  // Called right after a rising edge; returns right after the fire edge
  task automatic send(input logic [NW-1:0] num, input logic [DW-1:0] den,
                      input logic [PW-1:0] ctr, input logic [PW-1:0] epix,
                      input logic ezd, input logic esat, input int elat,
                      input bit expect_out = 1'b1);
    bit ok = 1'b0;
    if (expect_out) exp_q.push_back('{epix, ezd, esat, elat});
    in_num = num; in_den = den; in_center = ctr; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_num    = NW'($urandom);
    in_den    = DW'($urandom);
    in_center = PW'($urandom);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL input_accept: in_ready 0 required 1 within 50 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid),    32'd0);
    chk("rst_pixel",     32'(out_pixel),    32'd0);
    chk("rst_zero_den",  32'(out_zero_den), 32'd0);
    chk("rst_sat",       32'(out_sat),      32'd0);
    chk("rst_in_ready",  32'(in_ready),     32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(25'd200000, 13'd200, 12'd0, 12'd1000, 1'b0, 1'b0, 13); wait_idle();
    send(25'd7,      13'd2,   12'd0, 12'd4,    1'b0, 1'b0, 13); wait_idle();
    send(25'd5,      13'd2,   12'd0, 12'd3,    1'b0, 1'b0, 13); wait_idle();
    send(25'd6,      13'd4,   12'd0, 12'd2,    1'b0, 1'b0, 13); wait_idle();
    send(25'd5,      13'd4,   12'd0, 12'd1,    1'b0, 1'b0, 13); wait_idle();
    send(25'd999,    13'd0,   12'h123, 12'h123, 1'b1, 1'b0, 1); wait_idle();
    send(25'd5000,   13'd1,   12'd0, 12'd4095, 1'b0, 1'b1, 1);  wait_idle();
    send(25'd4094,   13'd1,   12'd0, 12'd4094, 1'b0, 1'b0, 13); wait_idle();
    send(25'd4095,   13'd1,   12'd0, 12'd4095, 1'b0, 1'b0, 13); wait_idle();
    send(25'd4096,   13'd1,   12'd7, 12'd4095, 1'b0, 1'b1, 1);  wait_idle();

    // Backpressure: result must stay frozen while out_ready is low
    out_ready = 1'b0;
    send(25'd200000, 13'd200, 12'd0, 12'd1000, 1'b0, 1'b0, 13);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("bp_out_valid_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after_fire",  32'(in_ready),  32'd1);
    chk("bp_out_valid_after_fire", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset during the 6th DIV cycle aborts the job with no output
    send(25'd1000, 13'd10, 12'd0, 12'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid_in_reset", 32'(out_valid), 32'd0);
    chk("abort_in_ready_in_reset",  32'(in_ready),  32'd1);
    fire_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("abort_no_output", 32'(out_valid), 32'd0);
    end
    chk("abort_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(25'd1000, 13'd10, 12'd0, 12'd100, 1'b0, 1'b0, 13); wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nlm_weight_normalizer.md
Name: nlm_weight_normalizer

Overview:
- Downstream of the two NLM adder trees.
  - Consumes the weighted-pixel sum (numerator) and the weight sum (denominator) for one output pixel.
  - Produces the normalized denoised pixel: round(num/den), saturated to the pixel range.
- Iterative restoring divider, one quotient bit per cycle, one pixel in flight.
- valid/ready handshake on both sides; feeds the NLM output writer.

Parameters:
- PIX_WIDTH, 12, pixel bit width; also the quotient width and the number of divide iterations.
- W_WIDTH, 8, per-tap weight bit width.
- LENGTH, 25, number of window taps summed by the adder trees.
- NUM_WIDTH (localparam), PIX_WIDTH+W_WIDTH+$clog2(LENGTH), numerator width.
- DEN_WIDTH (localparam), W_WIDTH+$clog2(LENGTH), denominator width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  num/den/center valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_num  in  NUM_WIDTH  sum of w_i*p_i, unsigned.
- in_den  in  DEN_WIDTH  sum of w_i, unsigned.
- in_center  in  PIX_WIDTH  centre pixel, used as fallback.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_pixel  out  PIX_WIDTH  normalized pixel.
- out_zero_den  out  1  result is the fallback because den==0.
- out_sat  out  1  result was clamped to 2^PIX_WIDTH-1.

Behaviour:
- One clock. Reset is asynchronous, active-low, applied to all state.
- Reset values:
  - State = IDLE.
  - in_ready=1 while in reset-released IDLE.
  - out_valid=0, out_pixel=0, out_zero_den=0, out_sat=0.
  - All internal registers are cleared to 0.
- The input transfer fires on in_valid&in_ready. The output transfer fires on out_valid&out_ready.
- FSM states: IDLE, DIV, DONE.
- IDLE, on input fire:
  - Latch den_r = in_den.
  - Latch rem = in_num + (in_den>>1). rem is NUM_WIDTH+1 bits wide, which implements round-half-up.
  - If in_den==0: out_pixel=in_center, out_zero_den=1, out_sat=0, go to DONE.
  - Else if in_num+(in_den>>1) >= in_den<<PIX_WIDTH (compare at NUM_WIDTH+1 bits): out_pixel=all ones, out_sat=1, go to DONE.
  - Else: clear the quotient, set bit index i=PIX_WIDTH-1, go to DIV.
- DIV, each cycle:
  - If rem >= (den_r<<i): rem -= den_r<<i and q[i]=1; else q[i]=0.
  - When i==0, register out_pixel=q (with the final bit included), clear both flags, and go to DONE. Otherwise decrement i.
  - The DIV phase lasts exactly PIX_WIDTH cycles.
- DONE:
  - out_valid=1; out_pixel and the flags are held stable until output fire.
  - On fire, go to IDLE with out_valid=0 in the next cycle.
- Latency from input fire to out_valid:
  - Normal case: PIX_WIDTH+1 cycles (13 at default).
  - Zero-den or saturation case: 1 cycle.
- Throughput: the next input is accepted at the earliest 1 cycle after output fire. No input/output overlap.
- in_ready is deasserted in DIV and DONE. Input values are ignored there and in_num/in_den may change freely.
- out_valid never drops without fire. out_ready asserted outside DONE has no effect.
- Asserting rst_n low mid-DIV or in DONE aborts the job immediately. No output is produced for it. After release the block is in IDLE.
- No arithmetic overflow is possible: the rem width covers in_num+(in_den>>1). The saturation pre-check guarantees the quotient fits in PIX_WIDTH bits.

Decomposition:
- Shared package nlm_pkg holds:
  - PIX_WIDTH, W_WIDTH and LENGTH defaults.
  - The derived NUM_WIDTH and DEN_WIDTH functions.
  - The FSM state encoding: IDLE=2'd0, DIV=2'd1, DONE=2'd2.
- Sub-module nlm_seq_divider: the restoring-division datapath (rem, q, bit index, start/busy/done).
- nlm_weight_normalizer keeps the handshake FSM, the zero-den and saturation pre-checks, and the output registers.

Test Plan:
- Nominal division: num=200000, den=200 -> out_pixel=1000, both flags 0, out_valid exactly 13 cycles after input fire.
- Rounding, half-up:
  - num=7, den=2 -> 4.
  - num=5, den=2 -> 3.
  - num=6, den=4 -> 2 (1.5 rounds up).
  - num=5, den=4 -> 1 (1.25 rounds down).
- Zero weight: den=0, center=0x123, num=999 -> out_pixel=0x123, out_zero_den=1, latency 1 cycle.
- Saturation:
  - num=5000, den=1 -> out_pixel=4095, out_sat=1, latency 1 cycle.
  - Boundary num=4094, den=1 -> 4094, no sat.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_pixel and flags stable, in_ready=0. Raise out_ready -> fire, then in_ready=1 on the following cycle.
- Reset mid-operation: assert rst_n=0 at the 6th DIV cycle -> out_valid=0 and in_ready=1 after release. A fresh job num=1000, den=10 then yields 100.
